sprite_blitter: RTL and testbench

- Parametrised successor to the fixed full-screen ROM-to-VGA copy loop.
- On a start pulse, copies one selectable 1-bit sprite image from ROM into a rectangle at a runtime origin, recolouring each pixel with runtime foreground and background colours.
- Drives the vga_adapter x/y/colour/plot inputs directly.
- Correctly compensates for ROM read latency, clips pixels that fall off-screen, and reports busy/done so a game controller can sequence several draws, e.g. user panel then computer panel.

---
 rtl/blit_pkg.sv | 19 +
 rtl/blit_delay_line.sv | 26 ++
 rtl/sprite_blitter.sv | 175 +++++++++++++++++
 tb/tb_sprite_blitter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/blit_pkg.sv
// Shared sprite-blitter types: control states, sprite IDs and palette constants.
package blit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] SPR_ROCK    = 2'd0;
    localparam logic [1:0] SPR_SCISSOR = 2'd1;
    localparam logic [1:0] SPR_PAPER   = 2'd2;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] WHITE = 3'b111;

endpackage

// File: rtl/blit_delay_line.sv
// Fixed-depth shift register that carries pixel coordinates alongside the ROM read.
// Latency DEPTH cycles, no backpressure: one entry in and one out every cycle.
module blit_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/sprite_blitter.sv
// Copies a 1-bit ROM sprite to a screen rectangle with fg/bg recolouring and edge clipping.
// One pixel per cycle; first plot ROM_LATENCY+2 cycles after start; no backpressure.
module sprite_blitter
    import blit_pkg::*;
#(
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120,
    parameter int X_BITS      = 8,
    parameter int Y_BITS      = 7,
    parameter int SPRITE_W    = 80,
    parameter int SPRITE_H    = 120,
    parameter int ADDR_BITS   = 14,
    parameter int SEL_BITS    = 2,
    parameter int COLOUR_BITS = 3,
    parameter int ROM_LATENCY = 1
) (
    input  logic                   CLOCK_50,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [SEL_BITS-1:0]    sprite_sel,
    input  logic [X_BITS-1:0]      x0,
    input  logic [Y_BITS-1:0]      y0,
    input  logic [COLOUR_BITS-1:0] fg_colour,
    input  logic [COLOUR_BITS-1:0] bg_colour,
    output logic [SEL_BITS-1:0]    rom_sel,
    output logic [ADDR_BITS-1:0]   rom_addr,
    input  logic                   rom_q,
    output logic [X_BITS-1:0]      x,
    output logic [Y_BITS-1:0]      y,
    output logic [COLOUR_BITS-1:0] colour,
    output logic                   plot,
    output logic                   busy,
    output logic                   done
);

    localparam int                DW         = X_BITS + Y_BITS + 1;
    localparam logic [X_BITS-1:0] COL_LAST   = X_BITS'(SPRITE_W - 1);
    localparam logic [Y_BITS-1:0] ROW_LAST   = Y_BITS'(SPRITE_H - 1);
    // Drain covers the ROM latency plus the output register, so done follows the last plot.
    localparam logic [2:0]        DRAIN_LAST = 3'(ROM_LATENCY + 1);

    state_t                   state_q, state_d;
    logic [X_BITS-1:0]        col_q, col_d, x0_q, x0_d;
    logic [Y_BITS-1:0]        row_q, row_d, y0_q, y0_d;
    logic [ADDR_BITS-1:0]     addr_q, addr_d;
    logic [SEL_BITS-1:0]      sel_q, sel_d;
    logic [COLOUR_BITS-1:0]   fg_q, fg_d, bg_q, bg_d;
    logic [2:0]               drain_q, drain_d;
    logic                     push_vld;

    logic [DW-1:0]            dl_out;
    logic [X_BITS-1:0]        t_col;
    logic [Y_BITS-1:0]        t_row;
    logic                     t_vld;
    logic [X_BITS:0]          x_sum;
    logic [Y_BITS:0]          y_sum;

    logic [X_BITS-1:0]        x_q;
    logic [Y_BITS-1:0]        y_q;
    logic [COLOUR_BITS-1:0]   colour_q;
    logic                     plot_q;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            sel_q   <= '0;
            x0_q    <= '0;
            y0_q    <= '0;
            fg_q    <= '0;
            bg_q    <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            fg_q    <= fg_d;
            bg_q    <= bg_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        addr_d   = addr_q;
        sel_d    = sel_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        fg_d     = fg_q;
        bg_d     = bg_q;
        drain_d  = drain_q;
        push_vld = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sel_d   = sprite_sel;
                    x0_d    = x0;
                    y0_d    = y0;
                    fg_d    = fg_colour;
                    bg_d    = bg_colour;
                    col_d   = '0;
                    row_d   = '0;
                    addr_d  = '0;
                    drain_d = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                push_vld = 1'b1;
                addr_d   = addr_q + 1'b1;
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    if (row_q == ROW_LAST) state_d = DRAIN;
                    else                   row_d   = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) state_d = DONE;
                else                       drain_d = drain_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    blit_delay_line #(
        .WIDTH (DW),
        .DEPTH (ROM_LATENCY)
    ) u_delay (
        .clk_i  (CLOCK_50),
        .rst_ni (reset_n),
        .din_i  ({col_q, row_q, push_vld}),
        .dout_o (dl_out)
    );

    assign t_col = dl_out[DW-1 -: X_BITS];
    assign t_row = dl_out[Y_BITS:1];
    assign t_vld = dl_out[0];
    assign x_sum = {1'b0, x0_q} + {1'b0, t_col};
    assign y_sum = {1'b0, y0_q} + {1'b0, t_row};

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
        end else begin
            x_q      <= x_sum[X_BITS-1:0];
            y_q      <= y_sum[Y_BITS-1:0];
            colour_q <= rom_q ? bg_q : fg_q;
            plot_q   <= t_vld && (x_sum < (X_BITS+1)'(SCREEN_W)) && (y_sum < (Y_BITS+1)'(SCREEN_H));
        end
    end

    assign rom_sel  = sel_q;
    assign rom_addr = addr_q;
    assign x        = x_q;
    assign y        = y_q;
    assign colour   = colour_q;
    assign plot     = plot_q;
    assign busy     = (state_q == SCAN) || (state_q == DRAIN);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: a 4x2 sprite drawn through ROM latencies 1 and 3,
// checked against a pixel-list model plus literal pixel tables.
module tb_sprite_blitter;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic       start_s [2];
    logic [1:0] sel_s   [2];
    logic [7:0] x0_s    [2];
    logic [6:0] y0_s    [2];
    logic [2:0] fg_s    [2];
    logic [2:0] bg_s    [2];
    logic [1:0] rsel_o  [2];
    logic [13:0] raddr_o[2];
    logic [7:0] x_o     [2];
    logic [6:0] y_o     [2];
    logic [2:0] c_o     [2];
    logic       plot_o  [2];
    logic       busy_o  [2];
    logic       done_o  [2];
    logic       r1, r3a, r3b, r3c;

    int   checks = 0;
    int   errors = 0;
    pix_t expq [2][$];
    pix_t obs  [2][$];
    int   first_plot [2];
    int   done_cnt   [2];
    int   done_cyc   [2];
    int   t0         [2];
    int   lx [8] = '{10, 11, 12, 13, 10, 11, 12, 13};
    int   ly [8] = '{5, 5, 5, 5, 6, 6, 6, 6};
    int   lc [8] = '{7, 2, 7, 2, 2, 2, 7, 7};

    // Sprite 0 is the documented pattern 1,0,1,0,0,0,1,1; sprite 2 is its inverse.
    function automatic logic rom_bit(input int sel, input int a);
        logic [7:0] pat;
        pat = 8'b1100_0101;
        if (a < 0 || a > 7) return 1'b0;
        return (sel == 2) ? ~pat[a] : pat[a];
    endfunction

    always @(posedge clk) begin
        r1  <= rom_bit(int'(rsel_o[0]), int'(raddr_o[0]));
        r3a <= rom_bit(int'(rsel_o[1]), int'(raddr_o[1]));
        r3b <= r3a;
        r3c <= r3b;
    end

    sprite_blitter #(.SPRITE_W(4), .SPRITE_H(2), .ROM_LATENCY(1)) dut1 (
        .CLOCK_50(clk), .reset_n(reset_n), .start(start_s[0]), .sprite_sel(sel_s[0]),
        .x0(x0_s[0]), .y0(y0_s[0]), .fg_colour(fg_s[0]), .bg_colour(bg_s[0]),
        .rom_sel(rsel_o[0]), .rom_addr(raddr_o[0]), .rom_q(r1),
        .x(x_o[0]), .y(y_o[0]), .colour(c_o[0]), .plot(plot_o[0]),
        .busy(busy_o[0]), .done(done_o[0])
    );

    sprite_blitter #(.SPRITE_W(4), .SPRITE_H(2), .ROM_LATENCY(3)) dut3 (
        .CLOCK_50(clk), .reset_n(reset_n), .start(start_s[1]), .sprite_sel(sel_s[1]),
        .x0(x0_s[1]), .y0(y0_s[1]), .fg_colour(fg_s[1]), .bg_colour(bg_s[1]),
        .rom_sel(rsel_o[1]), .rom_addr(raddr_o[1]), .rom_q(r3c),
        .x(x_o[1]), .y(y_o[1]), .colour(c_o[1]), .plot(plot_o[1]),
        .busy(busy_o[1]), .done(done_o[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every plot must be the next pixel of the model's raster-order list.
    always @(negedge clk) begin
        pix_t p, e;
        for (int d = 0; d < 2; d++) begin
            if (plot_o[d]) begin
                p = '{x: x_o[d], y: y_o[d], c: c_o[d]};
                obs[d].push_back(p);
                if (first_plot[d] < 0) first_plot[d] = cyc;
                if (expq[d].size() == 0) begin
                    chk($sformatf("unexpected_plot%0d", d), int'(p), -1);
                end else begin
                    e = expq[d].pop_front();
                    chk($sformatf("pixel%0d", d), int'(p), int'(e));
                end
            end
            if (done_o[d]) begin
                done_cnt[d]++;
                done_cyc[d] = cyc;
                chk($sformatf("busy_at_done%0d", d), int'(busy_o[d]), 0);
            end
        end
    end

    task automatic start_draw(input int d, input int sel, input int x0, input int y0,
                              input int fg, input int bg);
        int xx, yy;
        expq[d].delete();
        obs[d].delete();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++) begin
                xx = x0 + c;
                yy = y0 + r;
                if (xx < 160 && yy < 120)
                    expq[d].push_back('{x: 8'(xx), y: 7'(yy),
                                        c: rom_bit(sel, r*4 + c) ? 3'(bg) : 3'(fg)});
            end
        first_plot[d] = -1;
        done_cnt[d]   = 0;
        @(posedge clk); #1;
        sel_s[d] = 2'(sel); x0_s[d] = 8'(x0); y0_s[d] = 7'(y0);
        fg_s[d] = 3'(fg); bg_s[d] = 3'(bg);
        start_s[d] = 1'b1;
        t0[d] = cyc;
        @(posedge clk); #1;
        start_s[d] = 1'b0;
        fg_s[d] = ~fg_s[d];
        bg_s[d] = ~bg_s[d];
        y0_s[d] = y0_s[d] + 7'd40;
    endtask

    task automatic wait_done(input int d);
        int n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!done_o[d] && n < 200);
        if (!done_o[d]) chk($sformatf("done_timeout%0d", d), 0, 1);
    endtask

    task automatic finish_draw(input int d, input int lat_first, input int lat_done);
        wait_done(d);
        repeat (4) @(negedge clk);
        chk($sformatf("missing_plots%0d", d), expq[d].size(), 0);
        chk($sformatf("first_plot_lat%0d", d), first_plot[d] - t0[d], lat_first);
        chk($sformatf("done_lat%0d", d), done_cyc[d] - t0[d], lat_done);
        chk($sformatf("done_count%0d", d), done_cnt[d], 1);
    endtask

    task automatic lit_check(input int d);
        chk("lit_count", obs[d].size(), 8);
        for (int i = 0; i < obs[d].size() && i < 8; i++) begin
            chk($sformatf("lit_x%0d", i), int'(obs[d][i].x), lx[i]);
            chk($sformatf("lit_y%0d", i), int'(obs[d][i].y), ly[i]);
            chk($sformatf("lit_c%0d", i), int'(obs[d][i].c), lc[i]);
        end
    endtask

    initial begin
        int n;
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 1'b0; sel_s[d] = '0; x0_s[d] = '0; y0_s[d] = '0;
            fg_s[d] = '0; bg_s[d] = '0; first_plot[d] = -1; done_cnt[d] = 0;
            done_cyc[d] = 0; t0[d] = 0;
        end
        repeat (3) @(negedge clk);
        chk("rst_rom_addr", int'(raddr_o[0]), 0);
        chk("rst_rom_sel", int'(rsel_o[0]), 0);
        chk("rst_x", int'(x_o[0]), 0);
        chk("rst_y", int'(y_o[0]), 0);
        chk("rst_colour", int'(c_o[0]), 0);
        chk("rst_plot", int'(plot_o[0]), 0);
        chk("rst_busy", int'(busy_o[0]), 0);
        chk("rst_done", int'(done_o[0]), 0);
        chk("rst_busy3", int'(busy_o[1]), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic draw
        start_draw(0, 0, 10, 5, 2, 7);
        finish_draw(0, 3, 12);
        lit_check(0);

        // Right-edge clipping
        start_draw(0, 0, 158, 0, 2, 7);
        finish_draw(0, 3, 12);
        chk("clip_count", obs[0].size(), 4);

        // Second start while busy must be ignored
        start_draw(0, 0, 10, 5, 2, 7);
        repeat (3) @(posedge clk);
        #1 start_s[0] = 1'b1; x0_s[0] = 8'd50;
        @(posedge clk); #1 start_s[0] = 1'b0;
        finish_draw(0, 3, 12);
        lit_check(0);

        // Reset mid-draw
        start_draw(0, 0, 10, 5, 2, 7);
        n = 0;
        while (obs[0].size() < 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reached_3_plots", obs[0].size(), 3);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_plot", int'(plot_o[0]), 0);
        chk("abort_busy", int'(busy_o[0]), 0);
        chk("abort_done", int'(done_o[0]), 0);
        expq[0].delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("abort_no_done", done_cnt[0], 0);
        start_draw(0, 0, 10, 5, 2, 7);
        finish_draw(0, 3, 12);
        lit_check(0);

        // ROM latency 3
        start_draw(1, 0, 10, 5, 2, 7);
        finish_draw(1, 5, 14);
        lit_check(1);

        // Back-to-back: start in the cycle right after done
        start_draw(0, 0, 10, 5, 2, 7);
        wait_done(0);
        chk("b2b_first_complete", expq[0].size(), 0);
        start_draw(0, 2, 20, 30, 1, 6);
        @(negedge clk);
        chk("b2b_rom_sel", int'(rsel_o[0]), 2);
        chk("b2b_busy", int'(busy_o[0]), 1);
        finish_draw(0, 3, 12);
        chk("b2b_count", obs[0].size(), 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
